// File: rtl/ffd_load_arbiter_if.sv
// Requester/register-side bundle for ffd_load_arbiter.
// master = requester/bench side, slave = arbiter side.
interface ffd_load_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] d_out;
  logic             enabled;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             owner;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    output req0, data0, req1, data1,
    input  d_out, enabled, gnt0, gnt1,
    input  busy, owner, xfer_count
  );

  modport slave (
    input  req0, data0, req1, data1,
    output d_out, enabled, gnt0, gnt1,
    output busy, owner, xfer_count
  );
endinterface

// File: rtl/ffd_load_arbiter.sv
// Two-way round-robin loader for a shared enable-gated D register.
// Each transfer runs select -> LOAD (enabled) -> ACK (gnt) -> IDLE.
module ffd_load_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             reset,
  ffd_load_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]       state;
  logic             prio;
  logic [WIDTH-1:0] d_q;
  logic             en_q;
  logic             g0_q;
  logic             g1_q;
  logic             busy_q;
  logic             own_q;
  logic [CNT_W-1:0] cnt_q;
  logic             win;
  logic             any_req;

  assign any_req = bus.req0 | bus.req1;

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (bus.req0 & bus.req1):  win = prio;
      (bus.req1 & ~bus.req0): win = 1'b1;
      default:                win = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      prio   <= 1'b0;
      d_q    <= '0;
      en_q   <= 1'b0;
      g0_q   <= 1'b0;
      g1_q   <= 1'b0;
      busy_q <= 1'b0;
      own_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            d_q    <= win ? bus.data1 : bus.data0;
            own_q  <= win;
            busy_q <= 1'b1;
            en_q   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          en_q  <= 1'b0;
          g0_q  <= ~own_q;
          g1_q  <= own_q;
          state <= ACK;
        end
        ACK: begin
          g0_q   <= 1'b0;
          g1_q   <= 1'b0;
          busy_q <= 1'b0;
          prio   <= ~own_q;
          cnt_q  <= cnt_q + CNT_W'(1);
          state  <= IDLE;
        end
        default: begin
          en_q   <= 1'b0;
          g0_q   <= 1'b0;
          g1_q   <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.d_out      = d_q;
  assign bus.enabled    = en_q;
  assign bus.gnt0       = g0_q;
  assign bus.gnt1       = g1_q;
  assign bus.busy       = busy_q;
  assign bus.owner      = own_q;
  assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_ffd_load_arbiter.sv
// Self-checking bench: directed steps then random traffic vs a
// transaction-schedule reference model; second DUT checks CNT_W=2 wrap.
module tb_ffd_load_arbiter;

  logic clk;
  logic reset;

  ffd_load_arbiter_if #(.WIDTH(4), .CNT_W(8)) bus ();
  ffd_load_arbiter_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  assign bus2.req0  = bus.req0;
  assign bus2.req1  = bus.req1;
  assign bus2.data0 = bus.data0;
  assign bus2.data1 = bus.data1;

  ffd_load_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  ffd_load_arbiter #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic g0;
    logic g1;
    logic busy;
    logic done;
  } ev_t;

  ev_t        sched[$];
  logic       m_prio;
  logic [3:0] e_d;
  logic       e_en, e_g0, e_g1, e_busy, e_own;
  int         m_cnt;
  int         n_assert;
  int         n_fail;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    sched.delete();
    m_prio = 1'b0;
    e_d = 4'h0;
    e_en = 1'b0;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    e_busy = 1'b0;
    e_own = 1'b0;
    m_cnt = 0;
  endtask

  task automatic m_apply(input ev_t ev);
    e_en = ev.en;
    e_g0 = ev.g0;
    e_g1 = ev.g1;
    e_busy = ev.busy;
    if (ev.done) begin
      m_cnt++;
      m_prio = ~e_own;
    end
  endtask

  // One rising edge seen by the model with the inputs present at it.
  task automatic m_edge(input logic rs, input logic r0, input logic r1,
                        input logic [3:0] d0, input logic [3:0] d1);
    logic w;
    if (!rs) begin
      m_reset();
    end else if (sched.size() != 0) begin
      m_apply(sched.pop_front());
    end else if (r0 || r1) begin
      w = (r0 && r1) ? m_prio : r1;
      e_d = w ? d1 : d0;
      e_own = w;
      sched.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      sched.push_back('{1'b0, ~w, w, 1'b1, 1'b0});
      sched.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      m_apply(sched.pop_front());
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".d_out"}, 32'(bus.d_out), 32'(e_d));
    chk({tag, ".enabled"}, 32'(bus.enabled), 32'(e_en));
    chk({tag, ".gnt0"}, 32'(bus.gnt0), 32'(e_g0));
    chk({tag, ".gnt1"}, 32'(bus.gnt1), 32'(e_g1));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
    chk({tag, ".owner"}, 32'(bus.owner), 32'(e_own));
    chk({tag, ".cnt8"}, 32'(bus.xfer_count), 32'(m_cnt % 256));
    chk({tag, ".cnt2"}, 32'(bus2.xfer_count), 32'(m_cnt % 4));
  endtask

  task automatic tick(input string tag);
    logic rs, r0, r1;
    logic [3:0] d0, d1;
    rs = reset;
    r0 = bus.req0;
    r1 = bus.req1;
    d0 = bus.data0;
    d1 = bus.data1;
    @(posedge clk);
    #1;
    m_edge(rs, r0, r1, d0, d1);
    chk_all(tag);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    m_reset();
    reset = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.data0 = 4'b0101;
    bus.data1 = 4'b1111;

    tick("rst0");
    tick("rst1");
    chk("rst_en", 32'(bus.enabled), 32'd0);
    reset = 1'b1;

    // Contention: both held for three transfers.
    for (int i = 0; i < 9; i++) tick("cont");
    chk("cont_cnt", 32'(bus.xfer_count), 32'd3);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick("idle");

    // Single request.
    bus.req0 = 1'b1;
    bus.data0 = 4'b1010;
    tick("single_sel");
    chk("single_d", 32'(bus.d_out), 32'hA);
    tick("single_gnt");
    chk("single_g0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 1'b0;
    tick("single_end");

    // Data stability across LOAD.
    bus.req1 = 1'b1;
    bus.data1 = 4'b0011;
    tick("stab_sel");
    bus.data1 = 4'b1100;
    tick("stab_gnt");
    chk("stab_d", 32'(bus.d_out), 32'h3);
    bus.req1 = 1'b0;
    tick("stab_end");
    chk("stab_hold", 32'(bus.d_out), 32'h3);

    // Async reset during LOAD.
    bus.req1 = 1'b1;
    bus.data1 = 4'b0110;
    tick("abort_sel");
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    chk_all("abort_now");
    tick("abort_hold");
    reset = 1'b1;
    tick("abort_resel");
    tick("abort_gnt");
    chk("abort_g1", 32'(bus.gnt1), 32'd1);
    bus.req1 = 1'b0;
    tick("abort_end");
    chk("abort_cnt", 32'(bus.xfer_count), 32'd1);

    // Wrap on the narrow counter: five back-to-back transfers.
    bus.req0 = 1'b1;
    for (int i = 0; i < 15; i++) tick("wrap");
    bus.req0 = 1'b0;
    chk("wrap_cnt2", 32'(bus2.xfer_count), 32'd2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (bus.gnt0) bus.req0 = 1'b0;
      else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1'b1;
        bus.data0 = 4'($urandom);
      end
      if (bus.gnt1) bus.req1 = 1'b0;
      else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1'b1;
        bus.data1 = 4'($urandom);
      end
      if ($urandom_range(0, 7) == 0) bus.data0 = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.data1 = 4'($urandom);
      if ($urandom_range(0, 19) == 0) bus.req1 = 1'b0;
      reset = ($urandom_range(0, 99) != 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
